alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: execution core of the version-4 CPU. Fetches 12-bit
// instructions from a combinational program ROM, decodes them, drives the
// external 4-bit ALU and writes its result back into a 4-entry register file
// plus a registered zero flag.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | latch imem_data into IR, advance pc (wraps at 2**ADDR_W)
// EXEC   | execute IR: ALU write-back, LDI, JZ, NOP, or enter HALT
// HALT   | frozen until reset; halted=1
//
// Ports:
//   clk, reset           clock (rising edge), async active-high reset
//   imem_addr / imem_data instruction address (= pc) / instruction word
//   alu_a, alu_b, alu_opcode  ALU operands and opcode (zero unless EXEC of ALU op)
//   alu_result, alu_zero  combinational ALU result and zero flag
//   dbg_sel / dbg_data    combinational register-file read port
//   zero                  registered zero flag
//   halted                high in HALT
module alu_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [11:0]       imem_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              zero,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_JZ   = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [11:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   regs_q [4];
  logic [DATA_W-1:0]   regs_d [4];
  logic                zero_q, zero_d;

  logic [3:0]          op;
  logic [1:0]          rd, rs1, rs2;
  logic [3:0]          imm;
  logic [ADDR_W-1:0]   target;
  logic                is_alu;
  logic                exec_alu;

  assign op     = ir_q[11:8];
  assign rd     = ir_q[7:6];
  assign rs1    = ir_q[5:4];
  assign rs2    = ir_q[3:2];
  assign imm    = ir_q[3:0];
  assign target = ir_q[ADDR_W-1:0];

  // ADD..NOT form a contiguous opcode range.
  assign is_alu   = (op >= OP_ADD) && (op <= OP_NOT);
  assign exec_alu = (state_q == S_EXEC) && is_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zero_d  = zero_q;
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];

    unique case (state_q)
      S_FETCH: begin
        ir_d    = imem_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_alu) begin
          regs_d[rd] = alu_result;
          zero_d     = alu_zero;
        end else begin
          case (op)
            OP_LDI:  regs_d[rd] = DATA_W'(imm);
            // pc already points past the JZ; a taken branch overrides it.
            OP_JZ:   if (zero_q) pc_d = target;
            OP_HALT: state_d = S_HALT;
            default: ;
          endcase
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign imem_addr  = pc_q;
  assign alu_a      = exec_alu ? regs_q[rs1] : '0;
  assign alu_b      = (exec_alu && (op != OP_NOT)) ? regs_q[rs2] : '0;
  assign alu_opcode = exec_alu ? op : 4'b0000;
  assign dbg_data   = regs_q[dbg_sel];
  assign zero       = zero_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  imem_addr;
  logic [11:0] imem_data;
  logic [3:0]  alu_a, alu_b, alu_opcode, alu_result;
  logic        alu_zero;
  logic [1:0]  dbg_sel;
  logic [3:0]  dbg_data;
  logic        zero, halted;

  logic [11:0] rom [16];
  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .zero       (zero),
    .halted     (halted)
  );

  always #10 clk = ~clk;

  // Environment: program ROM and the 4-bit ALU.
  function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return ~a;
      default: return 4'd0;
    endcase
  endfunction

  assign imem_data  = rom[imem_addr];
  assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);
  assign alu_zero   = (alu_result == 4'd0);

  function automatic logic [11:0] enc_alu(input logic [3:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction
  function automatic logic [11:0] enc_ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {4'h8, rd, 2'b00, imm};
  endfunction
  function automatic logic [11:0] enc_jz(input logic [3:0] t);
    return {4'h9, 4'h0, t};
  endfunction
  localparam logic [11:0] I_HALT = 12'hF00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference model: architectural state plus whether the
  // next cycle executes the fetched word.
  logic [3:0]  m_pc;
  logic [11:0] m_ir;
  logic [3:0]  m_reg [4];
  logic        m_zero, m_exec, m_halt;
  int          m_op, m_a, m_b, m_r;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = 0; m_ir = 0; m_zero = 0; m_exec = 0; m_halt = 0;
      for (int i = 0; i < 4; i++) m_reg[i] = 0;
    end else if (!m_halt) begin
      if (!m_exec) begin
        m_ir   = rom[m_pc];
        m_pc   = 4'((int'(m_pc) + 1) % 16);
        m_exec = 1;
      end else begin
        m_exec = 0;
        m_op = int'(m_ir[11:8]);
        m_a  = int'(m_reg[m_ir[5:4]]);
        m_b  = int'(m_reg[m_ir[3:2]]);
        case (m_op)
          1: m_r = (m_a + m_b) % 16;
          2: m_r = (m_a - m_b + 16) % 16;
          3: m_r = m_a & m_b;
          4: m_r = m_a | m_b;
          5: m_r = m_a ^ m_b;
          6: m_r = 15 - m_a;
          default: m_r = 0;
        endcase
        if (m_op >= 1 && m_op <= 6) begin
          m_reg[m_ir[7:6]] = m_r[3:0];
          m_zero = (m_r == 0);
        end else if (m_op == 8) m_reg[m_ir[7:6]] = m_ir[3:0];
        else if (m_op == 9) begin
          if (m_zero) m_pc = m_ir[3:0];
        end else if (m_op == 15) m_halt = 1;
      end
    end
  end

  // Per-cycle compare process; also snapshots the register file via dbg.
  logic [3:0] dut_reg [4];
  int         add_cnt, not_cnt;
  logic [3:0] add_a, add_b, not_b;
  bit         r2_was_13;
  logic       e_alu;
  int         e_op;

  always begin
    @(negedge clk);
    e_op  = int'(m_ir[11:8]);
    e_alu = m_exec && !m_halt && (e_op >= 1) && (e_op <= 6);
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("alu_opcode", 32'(alu_opcode), e_alu ? 32'(e_op) : 32'd0);
    chk("alu_a", 32'(alu_a), e_alu ? 32'(m_reg[m_ir[5:4]]) : 32'd0);
    chk("alu_b", 32'(alu_b), (e_alu && e_op != 6) ? 32'(m_reg[m_ir[3:2]]) : 32'd0);
    chk("zero", 32'(zero), 32'(m_zero));
    chk("halted", 32'(halted), 32'(m_halt));
    if (alu_opcode == 4'd1) begin add_cnt++; add_a = alu_a; add_b = alu_b; end
    if (alu_opcode == 4'd6) begin not_cnt++; not_b = alu_b; end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      dut_reg[i] = dbg_data;
      chk($sformatf("reg%0d", i), 32'(dbg_data), 32'(m_reg[i]));
    end
    if (dut_reg[2] == 4'd13) r2_was_13 = 1;
  end

  // Main flow runs at negedge+6: after the snapshot, before the next posedge.
  task automatic hold_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    add_cnt = 0; not_cnt = 0; r2_was_13 = 0;
  endtask

  task automatic release_reset();
    @(negedge clk); #6;
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #6;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    add_cnt = 0; not_cnt = 0; r2_was_13 = 0;
    @(negedge clk); #6;

    // Load and add
    hold_reset();
    rom[0] = enc_ldi(2'd0, 4'd10);
    rom[1] = enc_ldi(2'd1, 4'd3);
    rom[2] = enc_alu(4'd1, 2'd2, 2'd0, 2'd1);
    rom[3] = I_HALT;
    release_reset();
    run(7);
    chk("t1_not_halted_at_7", 32'(halted), 32'd0);
    run(1);
    chk("t1_halted_at_8", 32'(halted), 32'd1);
    chk("t1_r2", 32'(dut_reg[2]), 32'd13);
    chk("t1_zero", 32'(zero), 32'd0);
    chk("t1_add_cycles", 32'(add_cnt), 32'd1);
    chk("t1_add_a", 32'(add_a), 32'd10);
    chk("t1_add_b", 32'(add_b), 32'd3);

    // Zero flag and branch
    hold_reset();
    rom[0] = enc_ldi(2'd0, 4'd5);
    rom[1] = enc_alu(4'd2, 2'd1, 2'd0, 2'd0);
    rom[2] = enc_jz(4'd7);
    rom[3] = enc_ldi(2'd2, 4'd1);
    rom[7] = I_HALT;
    release_reset();
    run(10);
    chk("t2_r1", 32'(dut_reg[1]), 32'd0);
    chk("t2_zero", 32'(zero), 32'd1);
    chk("t2_r2_untouched", 32'(dut_reg[2]), 32'd0);
    chk("t2_halted", 32'(halted), 32'd1);
    chk("t2_pc", 32'(imem_addr), 32'd8);

    // Wrap and logic
    hold_reset();
    rom[0] = enc_ldi(2'd0, 4'd10);
    rom[1] = enc_alu(4'd1, 2'd1, 2'd0, 2'd0);
    rom[2] = enc_alu(4'd6, 2'd2, 2'd0, 2'd0);
    rom[3] = enc_alu(4'd5, 2'd3, 2'd0, 2'd0);
    rom[4] = I_HALT;
    release_reset();
    run(10);
    chk("t3_r1_wrap", 32'(dut_reg[1]), 32'd4);
    chk("t3_r2_not", 32'(dut_reg[2]), 32'd5);
    chk("t3_r3_xor", 32'(dut_reg[3]), 32'd0);
    chk("t3_zero", 32'(zero), 32'd1);
    chk("t3_not_cycles", 32'(not_cnt), 32'd1);
    chk("t3_not_b", 32'(not_b), 32'd0);

    // PC wrap over an all-NOP ROM
    hold_reset();
    release_reset();
    for (int c = 1; c <= 34; c++) begin
      run(1);
      chk($sformatf("t4_addr_c%0d", c), 32'(imem_addr), 32'(((c + 1) / 2) % 16));
      chk("t4_not_halted", 32'(halted), 32'd0);
    end

    // Reset during EXEC of ADD r2,r0,r1 with zero already set
    hold_reset();
    rom[0] = enc_ldi(2'd0, 4'd10);
    rom[1] = enc_alu(4'd2, 2'd3, 2'd0, 2'd0);
    rom[2] = enc_ldi(2'd1, 4'd3);
    rom[3] = enc_alu(4'd1, 2'd2, 2'd0, 2'd1);
    rom[4] = I_HALT;
    release_reset();
    run(7);
    chk("t5_in_add_exec", 32'(alu_opcode), 32'd1);
    chk("t5_zero_before", 32'(zero), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_async_pc", 32'(imem_addr), 32'd0);
    chk("t5_async_opcode", 32'(alu_opcode), 32'd0);
    chk("t5_async_zero", 32'(zero), 32'd0);
    chk("t5_async_alu_a", 32'(alu_a), 32'd0);
    @(negedge clk); #6;
    for (int i = 0; i < 4; i++) chk($sformatf("t5_reg%0d_cleared", i), 32'(dut_reg[i]), 32'd0);
    chk("t5_r2_never_13", 32'(r2_was_13), 32'd0);

    // Undefined op then HALT, then freeze
    hold_reset();
    rom[0] = enc_ldi(2'd0, 4'd5);
    rom[1] = enc_alu(4'd2, 2'd1, 2'd0, 2'd0);
    rom[2] = enc_alu(4'd7, 2'd0, 2'd1, 2'd1);
    rom[3] = I_HALT;
    release_reset();
    run(8);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_pc", 32'(imem_addr), 32'd4);
    chk("t6_r0", 32'(dut_reg[0]), 32'd5);
    chk("t6_zero", 32'(zero), 32'd1);
    run(20);
    chk("t6_halted_after20", 32'(halted), 32'd1);
    chk("t6_pc_after20", 32'(imem_addr), 32'd4);
    chk("t6_r0_after20", 32'(dut_reg[0]), 32'd5);
    chk("t6_r1_after20", 32'(dut_reg[1]), 32'd0);
    chk("t6_zero_after20", 32'(zero), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
